trigger_link_tx_sequencer: RTL

// - TX bring-up/recovery sequencer for one trigger-link GT transmitter. Sits between the link reset logic and the GT wrapper.
// - Drives the GT PLL reset and GT TX reset, then waits for PLL lock and TX reset-done.
// - Retries on timeout or lock loss. Reports a qualified link_ready plus diagnostic counters.
// - One instance per link; outputs replace the free-running reset counters feeding the TX wrappers.

---
 rtl/trigger_link_tx_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/trigger_link_tx_sequencer.sv
// TX bring-up/recovery sequencer for one trigger-link GT transmitter; registered outputs, no backpressure.
// Lock loss in READY faults directly unless TRIG_LINK_AUTO_RECOVER_EN is defined (then it takes the retry path).
module trigger_link_tx_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 4096,
   parameter int GT_RST_CYCLES  = 16,
   parameter int DONE_TIMEOUT   = 4096,
   parameter int MAX_RETRIES    = 7
) (
   input  logic       clk_40,
   input  logic       reset_n,
   input  logic       restart_i,
   input  logic       pll_lock_i,
   input  logic       tx_resetdone_i,
   output logic       pll_reset_o,
   output logic       gt_tx_reset_o,
   output logic       link_ready_o,
   output logic       fault_o,
   output logic [2:0] state_o,
   output logic [7:0] retry_cnt_o,
   output logic [7:0] lock_loss_cnt_o
);

   localparam int MAX_WAIT = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
   localparam int MAX_RST  = (PLL_RST_CYCLES > GT_RST_CYCLES) ? PLL_RST_CYCLES : GT_RST_CYCLES;
   localparam int MAX_T    = (MAX_WAIT > MAX_RST) ? MAX_WAIT : MAX_RST;
   localparam int TW       = $clog2(MAX_T + 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_PLL_RST   = 3'd1;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
   localparam logic [2:0] ST_GT_RST    = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;
   localparam logic [2:0] ST_READY     = 3'd5;
   localparam logic [2:0] ST_FAULT     = 3'd6;

   logic [1:0]    lock_sync;
   logic [1:0]    done_sync;
   logic          lock_s;
   logic          done_s;
   logic [TW-1:0] timer;
   logic [2:0]    nxt_state;
   logic          do_retry;
   logic          lock_loss;

   assign lock_s = lock_sync[1];
   assign done_s = done_sync[1];

   always_ff @(posedge clk_40) begin
      if (!reset_n) begin
         lock_sync <= '0;
         done_sync <= '0;
      end else begin
         lock_sync <= {lock_sync[0], pll_lock_i};
         done_sync <= {done_sync[0], tx_resetdone_i};
      end
   end

   always_comb begin
      nxt_state = state_o;
      do_retry  = 1'b0;
      lock_loss = 1'b0;
      case (state_o)
         ST_IDLE:      nxt_state = ST_PLL_RST;
         ST_PLL_RST:   if (timer == TW'(PLL_RST_CYCLES - 1)) nxt_state = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            if (lock_s)                                nxt_state = ST_GT_RST;
            else if (timer == TW'(LOCK_TIMEOUT - 1))   do_retry  = 1'b1;
         end
         ST_GT_RST: begin
            if (!lock_s)                               do_retry  = 1'b1;
            else if (timer == TW'(GT_RST_CYCLES - 1))  nxt_state = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!lock_s)                               do_retry  = 1'b1;
            else if (done_s)                           nxt_state = ST_READY;
            else if (timer == TW'(DONE_TIMEOUT - 1))   do_retry  = 1'b1;
         end
         ST_READY: begin
            // resetdone glitches are the GT wrapper's business; only lock matters here
            if (!lock_s) begin
               lock_loss = 1'b1;
`ifdef TRIG_LINK_AUTO_RECOVER_EN
               do_retry  = 1'b1;
`else
               nxt_state = ST_FAULT;
`endif
            end
         end
         ST_FAULT:     nxt_state = ST_FAULT;
         default:      nxt_state = ST_IDLE;
      endcase
      if (do_retry)
         nxt_state = (retry_cnt_o == 8'(MAX_RETRIES)) ? ST_FAULT : ST_PLL_RST;
      if (restart_i)
         nxt_state = ST_PLL_RST;
   end

   always_ff @(posedge clk_40) begin
      if (!reset_n) begin
         state_o         <= ST_IDLE;
         timer           <= '0;
         retry_cnt_o     <= '0;
         lock_loss_cnt_o <= '0;
         pll_reset_o     <= 1'b1;
         gt_tx_reset_o   <= 1'b1;
         link_ready_o    <= 1'b0;
         fault_o         <= 1'b0;
      end else begin
         state_o <= nxt_state;

         if (restart_i || (nxt_state != state_o))
            timer <= '0;
         else if (timer != TW'(MAX_T))
            timer <= timer + 1'b1;

         if (restart_i)
            retry_cnt_o <= '0;
         else if (do_retry && (retry_cnt_o != 8'(MAX_RETRIES)) && (retry_cnt_o != 8'hFF))
            retry_cnt_o <= retry_cnt_o + 1'b1;

         if (lock_loss && !restart_i && (lock_loss_cnt_o != 8'hFF))
            lock_loss_cnt_o <= lock_loss_cnt_o + 1'b1;

         // outputs decoded from the next state so they line up with state_o
         pll_reset_o   <= (nxt_state == ST_IDLE) || (nxt_state == ST_PLL_RST) || (nxt_state == ST_FAULT);
         gt_tx_reset_o <= (nxt_state != ST_WAIT_DONE) && (nxt_state != ST_READY);
         link_ready_o  <= (nxt_state == ST_READY);
         fault_o       <= (nxt_state == ST_FAULT);
      end
   end

endmodule
